// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous FIFO.
// Turns registered FIFO reads into a valid/ready stream via a 2-entry skid buffer.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  logic [1:0]            occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  pop;
  logic                  issue;
  logic [2:0]            proj;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;

  // Occupancy the buffer would reach once the in-flight word lands.
  assign proj = {1'b0, occ}
              + {2'b00, inflight}
              - {2'b00, pop};

  assign issue = ~rst & en & ~fifo_empty
               & (proj < 3'd2);

  assign fifo_r_en  = issue;
  assign m_data     = buf0;
  assign busy       = inflight | m_valid;
  assign xfer_count = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
      cnt      <= '0;
    end else begin
      inflight <= issue;
      if (pop) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            buf0 <= fifo_rdata;
          end else begin
            buf1 <= fifo_rdata;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= fifo_rdata;
          end else begin
            buf0 <= buf1;
            buf1 <= fifo_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side controller for the team's synchronous FIFO.
- Drives the FIFO's read enable from its empty flag and registered read data, and presents the words as a valid/ready stream to a downstream consumer.
- Absorbs the FIFO's 1-cycle read latency with a 2-entry buffer, so that 1 word/cycle is sustained while m_ready stays high.
- Sits between the FIFO's read port and any stream sink: serializer, packetizer, or DMA write side.

Parameters:
DATA_WIDTH, 8, width of FIFO words and stream data
CNT_WIDTH, 16, width of the transferred-word counter

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
en  input  1  read enable; when low no new FIFO reads are issued
fifo_empty  input  1  FIFO empty flag
fifo_rdata  input  DATA_WIDTH  FIFO registered read data
fifo_r_en  output  1  FIFO read request
m_valid  output  1  stream word valid
m_ready  input  1  sink ready
m_data  output  DATA_WIDTH  stream word
busy  output  1  word in flight or buffered
xfer_count  output  CNT_WIDTH  number of completed stream transfers

Behaviour:
- FIFO contract: a read is accepted when fifo_r_en=1 and fifo_empty=0 at edge N. fifo_rdata holds that word from edge N until the next accepted read.
- State:
  - inflight (1 bit): an accepted read happened at the previous edge.
  - buf0/buf1: 2-entry in-order buffer.
  - occ: occupancy, 0..2.
- pop = m_valid & m_ready.
- issue = en & ~fifo_empty & ((occ + inflight - pop) < 2).
- fifo_r_en = issue. It is combinational, so a read is never requested while fifo_empty=1.
- At each edge:
  - If inflight=1, fifo_rdata is written into the buffer tail.
  - If pop=1, the head is removed.
  - Both may happen in the same cycle; occ then stays unchanged and data moves in order.
  - inflight <= issue.
- m_valid = (occ != 0). m_data = buffer head. Both come from registers; there is no combinational path from fifo_rdata to m_data.
- m_data must stay stable while m_valid=1 and m_ready=0.
- Latency: issue in cycle N -> word on m_valid in cycle N+2.
- Throughput: with m_ready held high and the FIFO non-empty, fifo_r_en is high every cycle and m_valid is high every cycle after the initial 2-cycle fill.
- Backpressure: with m_ready=0, at most 2 words are buffered, counting in-flight words. Reads stop before overflow; no word is dropped or duplicated.
- en deassert: no new issue. Any in-flight word is still captured, and buffered words drain normally.
- fifo_empty rising mid-stream: no further issue. Words already in flight or buffered are still delivered.
- busy = inflight | (occ != 0).
- xfer_count:
  - Increments by 1 on each pop.
  - Wraps from 2^CNT_WIDTH-1 to 0.
  - Is not cleared by en.
- Reset, when rst=1 at an edge, including mid-operation:
  - occ=0, inflight=0, xfer_count=0. Buffer contents are don't-care.
  - m_valid=0, busy=0. fifo_r_en=0 while rst=1.
  - A word in flight at reset is discarded. The FIFO is reset separately.
  - m_data reset value is 0.

Test Plan:
- Basic transfer: reset; FIFO preloaded with 0x11,0x22,0x33; en=1, m_ready=1 -> fifo_r_en high 3 consecutive cycles; m_data 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after the first read; xfer_count=3; busy low afterwards.
- Backpressure: FIFO holds 8 words; m_ready=0 -> exactly 2 reads accepted, then fifo_r_en stays 0; m_valid=1 with m_data=first word, stable. Release m_ready -> all 8 words delivered in order with no gaps after refill; xfer_count=8.
- Empty/stall: FIFO empty; en=1 -> fifo_r_en=0 and m_valid=0. One word 0xA5 written -> m_valid high with 0xA5 two cycles after the read is issued.
- Enable gating: en=0 with FIFO non-empty -> no fifo_r_en. Drop en with 1 word in flight and 1 buffered -> both still delivered, no further reads.
- Reset mid-operation: assert rst while occ=2 and inflight=1 -> next cycle m_valid=0, busy=0, xfer_count=0, fifo_r_en=0 during reset; operation resumes normally after rst=0.
- Counter wrap: CNT_WIDTH=4; 17 transfers -> xfer_count reads 1.
